mux_nway_reg: RTL and testbench
===============================

// Module: mux_nway_reg
// PURPOSE
// - Parametrised N-way, WIDTH-bit registered multiplexer with valid/ready flow control on every port.
// - Selects one input channel per cycle, either by an external select or by round-robin arbitration.
// - Holds the selected word in an output register with back-pressure. Used as the port-merge stage in switch datapaths.
// PARAMETERS
// - WIDTH   8   data bits per channel (>=1)
// - N       4   number of input channels (>=2)
// - MODE    0   0 = external select (sel), 1 = round-robin arbitration (sel ignored)
// - SEL_W   $clog2(N)   width of sel/out_src (derived localparam, not overridable)
// PORTS
// - clk        in   1        single clock, all state on rising edge
// - rst        in   1        synchronous reset, active-high
// - in_data    in   N*WIDTH  channel i at [i*WIDTH +: WIDTH]
// - in_valid   in   N        per-channel valid
// - in_ready   out  N        per-channel ready; at most one bit high per cycle
// - sel        in   SEL_W    channel select (MODE 0 only)
// - out_data   out  WIDTH    registered output word
// - out_valid  out  1        out_data holds an untaken word
// - out_ready  in   1        downstream accepts when out_valid & out_ready
// - out_src    out  SEL_W    index of the channel that produced out_data
// BEHAVIOUR
// - Reset (rst=1 at edge): out_valid=0, out_data=0, out_src=0, rr_ptr=0.
//   - In-flight output word is discarded.
//   - in_ready is 0 during every cycle with rst=1.
// - load = !out_valid | out_ready. Output register can accept a word this cycle.
//   - This allows full throughput: one word per cycle with no bubble.
// - Grant (combinational, one-hot or zero):
//   - MODE 0: grant[sel] = in_valid[sel] when sel < N.
//   - MODE 0: no grant when sel >= N, including out-of-range values for non-power-of-2 N.
//   - MODE 1: the first i with in_valid[i] set, scanning rr_ptr, rr_ptr+1, ... mod N.
// - in_ready[i] = grant[i] & load & !rst.
// - Transfer on channel i when in_valid[i] & in_ready[i]. At the next edge:
//   - out_data  <= channel i data
//   - out_src   <= i
//   - out_valid <= 1
//   - Latency is 1 cycle from input handshake to out_valid.
// - If load=1 and there is no grant: out_valid <= 0. out_data and out_src are held (don't-care).
// - If out_valid=1 and out_ready=0: out_data, out_src and out_valid are held stable, and all in_ready = 0.
// - rr_ptr (MODE 1 only):
//   - After a transfer on channel i: rr_ptr <= (i+1) mod N. Wrap N-1 -> 0.
//   - Held when there is no transfer.
//   - Guarantees no channel waits more than N-1 transfers.
// - Inputs need not hold data/valid after a transfer. An un-granted input may drop valid without penalty.
// - No combinational path from out_ready to out_data. A path from out_ready to in_ready is permitted.
// TESTING
// - Reset: rst=1 for 2 cycles with all in_valid=1.
//   -> out_valid=0, out_data=0, out_src=0, in_ready=0. First grant after release goes to ch0 (MODE 1).
// - MODE 0 streaming: N=4, sel=2, in_valid=4'b0100, data2=0xA5, out_ready=1.
//   -> in_ready=4'b0100. Next cycle out_data=0xA5, out_src=2. A new word is accepted every cycle.
// - MODE 0 bad select: N=3, sel=3, all valid.
//   -> in_ready=0. out_valid falls to 0 after the pending word drains.
// - Back-pressure: out_valid=1, out_ready=0 for 5 cycles.
//   -> out_data and out_src are unchanged and in_ready=0 throughout. On out_ready=1, the next word loads the same cycle.
// - MODE 1 fairness: N=4, all valid continuously, out_ready=1.
//   -> out_src sequence 0,1,2,3,0. With only ch1 and ch3 valid: 1,3,1,3.
// - Reset mid-operation: rst=1 while out_valid=1, out_ready=0, rr_ptr=2.
//   -> word dropped, out_valid=0, and the next MODE 1 grant starts scanning at ch0.

Source files
------------

// File: rtl/mux_nway_reg.sv
// N-way, WIDTH-bit registered multiplexer with valid/ready flow control.
// Picks one input channel per cycle, either from an external select (MODE 0)
// or by round-robin arbitration (MODE 1). The chosen word is held in an
// output register that supports back-pressure without losing throughput.
module mux_nway_reg #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    parameter  int MODE  = 0,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SEL_W-1:0]     sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SEL_W-1:0]     out_src
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_out_src;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_load;
    logic             w_take;
    logic             w_grant_any;
    logic [SEL_W-1:0] w_grant_idx;
    logic [WIDTH-1:0] w_sel_data;

    // The output register can take a word when empty or being drained this cycle.
    assign w_load = !r_out_valid || out_ready;
    assign w_take = w_grant_any && w_load && !rst;

    // Grant: the selected channel (MODE 0) or the closest valid channel at or after rr_ptr (MODE 1).
    always_comb begin
        int v_dist;
        int v_best;
        // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        v_best      = N;
        v_dist      = 0;
        for (int i = 0; i < N; i++) begin
            if (MODE == 0) begin
                // Comparing against the loop index keeps out-of-range selects from ever granting.
                if (in_valid[i] && (int'(sel) == i)) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = SEL_W'(i);
                end
            end else begin
                v_dist = i - int'(r_rr_ptr);
                if (v_dist < 0) begin
                    v_dist = v_dist + N;
                end
                if (in_valid[i] && (v_dist < v_best)) begin
                    v_best      = v_dist;
                    w_grant_any = 1'b1;
                    w_grant_idx = SEL_W'(i);
                end
            end
        end
    end

    // Ready is one-hot on the granted channel, and only when the output register can load.
    always_comb begin
        in_ready   = '0;
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant_idx == SEL_W'(i)) begin
                in_ready[i] = w_take;
                w_sel_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and round-robin pointer; everything holds while stalled.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            if (w_grant_any) begin
                r_out_data  <= w_sel_data;
                r_out_src   <= w_grant_idx;
                r_out_valid <= 1'b1;
                if (MODE == 1) begin
                    r_rr_ptr <= (w_grant_idx == SEL_W'(N - 1)) ? '0 : w_grant_idx + 1'b1;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_nway_reg.sv
// Scoreboard bench for mux_nway_reg: two N=4 instances (select and round-robin)
// share random stimulus; an N=3 instance covers out-of-range selects.
module tb_mux_nway_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [1:0]  sel;
    logic        out_ready;
    logic [3:0]  rdy [2];
    logic [7:0]  od  [2];
    logic        ov  [2];
    logic [1:0]  os  [2];

    logic [23:0] in_data_c;
    logic [2:0]  in_valid_c;
    logic [1:0]  sel_c;
    logic        or_c;
    logic [2:0]  rdy_c;
    logic [7:0]  od_c;
    logic        ov_c;
    logic [1:0]  os_c;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-instance occupancy and round-robin pointer, expected words queued.
    bit         m_occ [2];
    int         m_ptr [2];
    logic [9:0] sb0 [$];
    logic [9:0] sb1 [$];
    int         src_log [$];

    always #5 clk = ~clk;

    mux_nway_reg #(.WIDTH(8), .N(4), .MODE(0)) u_sel (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
        .sel(sel), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_src(os[0]));

    mux_nway_reg #(.WIDTH(8), .N(4), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
        .sel(sel), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_src(os[1]));

    mux_nway_reg #(.WIDTH(8), .N(3), .MODE(0)) u_n3 (
        .clk(clk), .rst(rst), .in_data(in_data_c), .in_valid(in_valid_c), .in_ready(rdy_c),
        .sel(sel_c), .out_data(od_c), .out_valid(ov_c), .out_ready(or_c), .out_src(os_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel the spec's grant rule picks, or -1 for none.
    function automatic int grant_of(input int mode, input logic [3:0] v, input logic [1:0] s, input int ptr);
        if (mode == 0) begin
            return v[s] ? int'(s) : -1;
        end
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    // One clock cycle: drive, check ready/valid against the model, queue expected words.
    task automatic cycle(input bit r, input logic [3:0] v, input logic [31:0] d,
                         input logic [1:0] s, input bit ordy);
        logic [3:0] exp_rdy;
        int         g;
        bit         load;
        rst = r; in_valid = v; in_data = d; sel = s; out_ready = ordy;
        #1;
        for (int m = 0; m < 2; m++) begin
            g       = grant_of(m, v, s, m_ptr[m]);
            load    = !m_occ[m] || ordy;
            exp_rdy = '0;
            if (!r && load && g >= 0) exp_rdy[g] = 1'b1;
            check(m == 0 ? "sel_in_ready" : "rr_in_ready", 32'(rdy[m]), 32'(exp_rdy));
            check(m == 0 ? "sel_out_valid" : "rr_out_valid", 32'(ov[m]), 32'(m_occ[m]));
            if (r) begin
                m_occ[m] = 1'b0;
                m_ptr[m] = 0;
                if (m == 0) sb0.delete(); else sb1.delete();
            end else if (exp_rdy != 0) begin
                m_occ[m] = 1'b1;
                if (m == 0) sb0.push_back({d[g*8 +: 8], 2'(g)});
                else begin
                    sb1.push_back({d[g*8 +: 8], 2'(g)});
                    m_ptr[m] = (g + 1) % 4;
                end
            end else if (load) begin
                m_occ[m] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake pops the oldest expected word and compares it.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst === 1'b0 && out_ready === 1'b1) begin
            for (int m = 0; m < 2; m++) begin
                if (ov[m] === 1'b1) begin
                    if ((m == 0 ? sb0.size() : sb1.size()) == 0) begin
                        check("unexpected_output", 32'(m), 32'hFFFF_FFFF);
                    end else begin
                        e = (m == 0) ? sb0.pop_front() : sb1.pop_front();
                        check(m == 0 ? "sel_out_data" : "rr_out_data", 32'(od[m]), 32'(e[9:2]));
                        check(m == 0 ? "sel_out_src" : "rr_out_src", 32'(os[m]), 32'(e[1:0]));
                        if (m == 1) src_log.push_back(int'(os[1]));
                    end
                end
            end
        end
    end

    task automatic check_log(input string name, input int exp_q [$]);
        check({name, "_len"}, 32'(src_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < src_log.size(); i++) begin
            check(name, 32'(src_log[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 4'hF; in_data = '0; sel = '0; out_ready = 1'b0;
        in_data_c = '0; in_valid_c = '0; sel_c = '0; or_c = 1'b0;
        m_occ[0] = 1'b0; m_occ[1] = 1'b0; m_ptr[0] = 0; m_ptr[1] = 0;
        @(posedge clk);
        #1;

        // Reset held two cycles with every channel valid.
        repeat (2) cycle(1'b1, 4'hF, $urandom(), 2'd0, 1'b0);
        for (int m = 0; m < 2; m++) begin
            check("reset_out_data", 32'(od[m]), 32'h0);
            check("reset_out_src", 32'(os[m]), 32'h0);
        end

        // Round-robin fairness straight after reset: all valid, then only ch1/ch3.
        src_log.delete();
        repeat (5) cycle(1'b0, 4'hF, $urandom(), 2'd0, 1'b1);
        cycle(1'b0, 4'h0, $urandom(), 2'd0, 1'b1);
        check_log("rr_all_seq", '{0, 1, 2, 3, 0});
        src_log.delete();
        repeat (4) cycle(1'b0, 4'b1010, $urandom(), 2'd0, 1'b1);
        cycle(1'b0, 4'h0, $urandom(), 2'd0, 1'b1);
        check_log("rr_13_seq", '{1, 3, 1, 3});

        // Select streaming on channel 2.
        cycle(1'b0, 4'b0100, 32'h00A5_0000, 2'd2, 1'b1);
        check("stream_data", 32'(od[0]), 32'hA5);
        check("stream_src", 32'(os[0]), 32'd2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0100, $urandom(), 2'd2, 1'b1);

        // Back-pressure: five stalled cycles, the held word must match the oldest expected one.
        cycle(1'b0, 4'hF, $urandom(), 2'd1, 1'b1);
        repeat (5) begin
            cycle(1'b0, 4'hF, $urandom(), 2'd1, 1'b0);
            check("stall_data", 32'(od[0]), 32'(sb0[0][9:2]));
            check("stall_src", 32'(os[0]), 32'(sb0[0][1:0]));
        end
        cycle(1'b0, 4'hF, $urandom(), 2'd1, 1'b1);

        // Reset mid-operation with rr_ptr=2 and a stalled word.
        cycle(1'b0, 4'b0010, $urandom(), 2'd0, 1'b1);
        cycle(1'b0, 4'h0, $urandom(), 2'd0, 1'b0);
        cycle(1'b1, 4'hF, $urandom(), 2'd0, 1'b0);
        check("midrst_out_valid", 32'(ov[1]), 32'h0);
        check("midrst_out_data", 32'(od[1]), 32'h0);
        src_log.delete();
        cycle(1'b0, 4'hF, $urandom(), 2'd0, 1'b1);
        cycle(1'b0, 4'h0, $urandom(), 2'd0, 1'b1);
        check_log("midrst_first", '{0});

        // Randomised traffic with occasional resets and back-pressure.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) == 0, 4'($urandom_range(0, 15)), $urandom(),
                  2'($urandom_range(0, 3)), $urandom_range(0, 9) < 7);
        end
        repeat (3) cycle(1'b0, 4'h0, $urandom(), 2'd0, 1'b1);
        check("sel_drained", 32'(sb0.size()), 32'h0);
        check("rr_drained", 32'(sb1.size()), 32'h0);

        // N=3, select out of range: load one word via sel=1, then sel=3 must never grant.
        in_data_c = 24'h33_22_11; in_valid_c = 3'b111; sel_c = 2'd1; or_c = 1'b0;
        #1;
        check("n3_in_ready_sel1", 32'(rdy_c), 32'b010);
        @(posedge clk);
        #1;
        check("n3_out_valid", 32'(ov_c), 32'h1);
        check("n3_out_data", 32'(od_c), 32'h22);
        check("n3_out_src", 32'(os_c), 32'h1);
        sel_c = 2'd3; or_c = 1'b1;
        #1;
        check("n3_in_ready_bad_sel", 32'(rdy_c), 32'h0);
        @(posedge clk);
        #1;
        check("n3_drained", 32'(ov_c), 32'h0);
        check("n3_in_ready_idle", 32'(rdy_c), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
